mem_access_unit: RTL and testbench

- Load/store sequencer between the core's execute/memory stage and the 1024x32 word-addressed BRAM.
- Takes byte-addressed load/store requests of byte, half or word size and drives the BRAM's active-low read and write strobes.
- Performs read-modify-write for sub-word stores, and alignment plus sign/zero extension for loads.
- The BRAM samples strobes and address on the falling clock edge. A strobe driven from one rising edge therefore completes before the next rising edge.

---
 rtl/mem_access_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Load/store sequencer between the execute/memory stage and a 1024x32
// word-addressed BRAM.
// Byte, half and word requests arrive byte-addressed. The unit drives the
// BRAM's active-low read and write strobes. It performs read-modify-write
// for sub-word stores. Loads are aligned and then sign- or zero-extended.
//
// The BRAM samples address and strobes on the falling clock edge. A strobe
// registered on one rising edge has therefore completed by the next rising
// edge, so each memory phase lasts exactly one cycle.
//
// Handshake: the request is a single-cycle offer. req_i is sampled only
// while busy_o is low (IDLE). Once accepted, the request fields are
// registered and the inputs become don't-care. A request made while busy_o
// is high is dropped, not queued. Every accepted request ends with exactly
// one done_o pulse. misalign_o is meaningful only while done_o is high. An
// aborting reset produces no done_o.
//
// Configuration macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   - a request faults if size is 11, if a half access has
//               addr[0]=1, or if a word access has addr[1:0]!=0. A faulting
//               request completes with misalign_o=1 and never touches memory.
//   undefined - misalign_o is tied 0. Half accesses ignore addr[0], word
//               accesses ignore addr[1:0], and size 11 is treated as word.
//
// Ports:
//   clk_i, reset_i       clock (rising edge), synchronous active-high reset
//   req_i, we_i          request strobe; 1=store, 0=load
//   size_i               00=byte, 01=half, 10=word, 11=illegal
//   unsigned_i           zero-extend loads when 1, sign-extend when 0
//   addr_i               byte address (WORDS+2 bits)
//   wdata_i              store data, right-justified
//   busy_o               high whenever the FSM is not IDLE
//   done_o               one-cycle completion pulse
//   rdata_o              extended load result, held until the next load
//   misalign_o           fault flag, valid with done_o
//   mem_addr_o           BRAM word address
//   mem_data_o           BRAM write data
//   mem_wr_o, mem_rd_o   BRAM write/read enables, active-low
//   mem_data_i           BRAM read data
//   dbg_state_o          current FSM state, for debug and checkers

module mem_access_unit #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [WORDS+1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misalign_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [1:0]              lane_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    fault_c;
    logic                    is_word_c;
    logic [1:0]              size_norm_c;

    // Pick the addressed byte or half out of a word, then extend it to 32
    // bits. Half lanes use only lane[1], so the unused low address bit has
    // no effect when faults are disabled.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] w,
        input logic [1:0]            sz,
        input logic [1:0]            lane,
        input logic                  uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: extract = {{24{~uns & b[7]}}, b};
            SZ_HALF: extract = {{16{~uns & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Overwrite only the addressed lane(s) of the old word. Every other bit
    // passes through unchanged.
    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] w,
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            sz,
        input logic [1:0]            lane
    );
        logic [DATA_WIDTH-1:0] m;
        m = w;
        case (sz)
            SZ_BYTE: m[{lane, 3'b000} +: 8] = d[7:0];
            SZ_HALF: begin
                if (lane[1]) m[31:16] = d[15:0];
                else         m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        merge = m;
    endfunction

    always_comb begin
        // Size 11 is folded into word. When faults are enabled it never
        // reaches the datapath because it traps first.
        size_norm_c = (size_i == 2'b11) ? SZ_WORD : size_i;
        is_word_c   = (size_norm_c == SZ_WORD);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        fault_c = (size_i == 2'b11)
               || ((size_i == SZ_HALF) && addr_i[0])
               || ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
        fault_c = 1'b0;
`endif
    end

    assign busy_o      = (state != S_IDLE);
    assign dbg_state_o = state;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            rdata_o    <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_wr_o   <= 1'b1;
            mem_rd_o   <= 1'b1;
        end else begin
            // Strobes and pulses default inactive. Each state that needs
            // one asserts it for exactly the following cycle.
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            mem_wr_o   <= 1'b1;
            mem_rd_o   <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        we_q       <= we_i;
                        size_q     <= size_norm_c;
                        unsigned_q <= unsigned_i;
                        lane_q     <= addr_i[1:0];
                        wdata_q    <= wdata_i;
                        mem_addr_o <= addr_i[WORDS+1:2];
                        if (fault_c) begin
                            state      <= S_RESP;
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                        end else if (we_i && is_word_c) begin
                            // A full-word store needs no read phase.
                            state      <= S_WR;
                            mem_wr_o   <= 1'b0;
                            mem_data_o <= wdata_i;
                        end else begin
                            state    <= S_RD;
                            mem_rd_o <= 1'b0;
                        end
                    end
                end

                S_RD: begin
                    // mem_data_i became valid at the falling edge of the RD
                    // cycle, so it is consumed on this rising edge.
                    if (we_q) begin
                        state      <= S_WR;
                        mem_wr_o   <= 1'b0;
                        mem_data_o <= merge(mem_data_i, wdata_q, size_q, lane_q);
                    end else begin
                        state   <= S_RESP;
                        done_o  <= 1'b1;
                        rdata_o <= extract(mem_data_i, size_q, lane_q, unsigned_q);
                    end
                end

                S_WR: begin
                    state  <= S_RESP;
                    done_o <= 1'b1;
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A behavioural BRAM sits on the
// falling edge. A byte-array reference model predicts load results,
// latencies, strobe counts and final memory contents.
module tb_mem_access_unit;

    localparam int WORDS = 10;
    localparam int NBYTES = 4 << WORDS;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [1:0]        size_i = 2'b00;
    logic              unsigned_i = 1'b0;
    logic [WORDS+1:0]  addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic              busy_o;
    logic              done_o;
    logic [31:0]       rdata_o;
    logic              misalign_o;
    logic [WORDS-1:0]  mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_wr_o;
    logic              mem_rd_o;
    logic [31:0]       mem_data_i = '0;
    logic [1:0]        dbg_state_o;

    int checks = 0;
    int fails  = 0;
    int done_seen = 0;

    logic [31:0] bram [1024];
    logic [7:0]  ref_b [NBYTES];
    logic [31:0] exp_q [$];
    logic [31:0] last_rdata = '0;

    mem_access_unit #(.WORDS(WORDS), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .rdata_o(rdata_o), .misalign_o(misalign_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o),
        .mem_data_i(mem_data_i), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // BRAM model: samples strobes on the falling edge. The same edge also
    // watches strobe exclusivity and counts completion pulses.
    always @(negedge clk) begin
        if (!mem_rd_o) mem_data_i <= bram[mem_addr_o];
        if (!mem_wr_o) bram[mem_addr_o] <= mem_data_o;
        if (done_o) done_seen++;
        if (!mem_rd_o || !mem_wr_o) begin
            checks++;
            if (!mem_rd_o && !mem_wr_o) begin
                fails++;
                $display("FAIL strobe_excl: rd=%b wr=%b, required not both low", mem_rd_o, mem_wr_o);
            end
        end
    end

    function automatic logic [31:0] ref_word(input int w);
        ref_word = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        bram[w] = v;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = v[8*i +: 8];
    endtask

    // Reference model: decides fault, latency and strobe counts from the
    // request rules, and updates the byte array.
    task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [WORDS+1:0] a, input logic [31:0] wd,
                             output bit fault, output int lat, output int rds, output int wrs);
        int n, ai, base;
        logic [31:0] v;
        fault = 0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) fault = 1;
`endif
        if (fault) begin
            lat = 1; rds = 0; wrs = 0;
            return;
        end
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ai = int'(a);
        base = ai - (ai % n);
        if (we) begin
            for (int i = 0; i < n; i++) ref_b[base+i] = wd[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
            rds = (n == 4) ? 0 : 1;
            wrs = 1;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[base+i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_q.push_back(v);
            last_rdata = v;
            lat = 2; rds = 1; wrs = 0;
        end
    endtask

    // One request, issued in the first IDLE cycle, checked end to end.
    task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [WORDS+1:0] a, input logic [31:0] wd, input string tag);
        bit f;
        int elat, erds, ewrs;
        int lat, rds, wrs;
        logic [31:0] exp_r;
        model_req(we, sz, uns, a, wd, f, elat, erds, ewrs);
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
        @(posedge clk); #1;
        // Inputs are don't-care once captured.
        req_i = 1'b0; we_i = 1'($urandom); size_i = 2'($urandom_range(3, 0));
        unsigned_i = 1'($urandom); addr_i = (WORDS+2)'($urandom); wdata_i = $urandom;
        lat = 1; rds = 0; wrs = 0;
        while (!done_o && lat < 10) begin
            if (!mem_rd_o) rds++;
            if (!mem_wr_o) wrs++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != elat) begin fails++; $display("FAIL %s latency: got %0d required %0d", tag, lat, elat); end
        checks++;
        if (misalign_o !== f) begin fails++; $display("FAIL %s misalign: got %b required %b", tag, misalign_o, f); end
        checks++;
        if (busy_o !== 1'b1) begin fails++; $display("FAIL %s busy_at_done: got %b required 1", tag, busy_o); end
        checks++;
        if (rds != erds || wrs != ewrs) begin
            fails++;
            $display("FAIL %s strobes: got rd=%0d wr=%0d required rd=%0d wr=%0d", tag, rds, wrs, erds, ewrs);
        end
        if (!we && !f) exp_r = exp_q.pop_front();
        else exp_r = last_rdata;
        checks++;
        if (rdata_o !== exp_r) begin fails++; $display("FAIL %s rdata: got %h required %h", tag, rdata_o, exp_r); end
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after: busy=%b done=%b required 0 0", tag, busy_o, done_o);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || misalign_o !== 1'b0 || rdata_o !== 32'h0 ||
            mem_addr_o !== '0 || mem_data_o !== 32'h0 || mem_wr_o !== 1'b1 || mem_rd_o !== 1'b1) begin
            fails++;
            $display("FAIL %s reset_outputs: busy=%b done=%b mis=%b rdata=%h addr=%h data=%h wr=%b rd=%b required 0 0 0 0 0 0 1 1",
                     tag, busy_o, done_o, misalign_o, rdata_o, mem_addr_o, mem_data_o, mem_wr_o, mem_rd_o);
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("test_reset");
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("test_reset_released");
    endtask

    task automatic test_directed;
        do_txn(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, "word_store");
        checks++;
        if (bram[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL word_store_mem: got %h required deadbeef", bram[4]); end
        do_txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, "word_load");
        checks++;
        if (rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load_const: got %h required deadbeef", rdata_o); end
        preload(5, 32'h11223344);
        do_txn(1'b1, 2'b00, 1'b0, 12'h016, 32'h123456AB, "byte_store");
        checks++;
        if (bram[5] !== 32'h11AB3344) begin fails++; $display("FAIL byte_store_mem: got %h required 11ab3344", bram[5]); end
        do_txn(1'b0, 2'b00, 1'b0, 12'h016, 32'h0, "byte_load_s");
        checks++;
        if (rdata_o !== 32'hFFFFFFAB) begin fails++; $display("FAIL byte_load_s_const: got %h required ffffffab", rdata_o); end
        do_txn(1'b0, 2'b00, 1'b1, 12'h016, 32'h0, "byte_load_u");
        checks++;
        if (rdata_o !== 32'h000000AB) begin fails++; $display("FAIL byte_load_u_const: got %h required 000000ab", rdata_o); end
        do_txn(1'b0, 2'b01, 1'b0, 12'h016, 32'h0, "half_load_s");
        checks++;
        if (rdata_o !== 32'h000011AB) begin fails++; $display("FAIL half_load_s_const: got %h required 000011ab", rdata_o); end
        // Misaligned half store: traps when faults are enabled, otherwise
        // lands in the upper half of word 4.
        do_txn(1'b1, 2'b01, 1'b0, 12'h013, 32'hCAFE5A5A, "half_store_odd");
        checks++;
        if (bram[4] !== ref_word(4)) begin fails++; $display("FAIL half_store_odd_mem: got %h required %h", bram[4], ref_word(4)); end
        // Top byte address maps to the last word.
        do_txn(1'b1, 2'b00, 1'b0, 12'hFFF, 32'h0000007E, "top_byte_store");
        do_txn(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, "top_word_load");
    endtask

    task automatic test_random;
        logic [WORDS+1:0] a;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(9, 0) == 0) a = (WORDS+2)'(NBYTES - 8 + int'($urandom_range(7, 0)));
            else a = (WORDS+2)'($urandom_range(63, 0));
            do_txn(1'($urandom), 2'($urandom_range(3, 0)), 1'($urandom), a, $urandom, "random");
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] wd;
        int d0;
        for (int k = 1; k <= 2; k++) begin
            do_txn(1'b1, 2'b10, 1'b0, 12'h040, $urandom, "rm_word_store");
            wd = $urandom;
            @(negedge clk);
            req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 12'h041; wdata_i = wd;
            @(posedge clk); #1;
            req_i = 1'b0;
            if (k == 2) begin @(posedge clk); #1; end
            d0 = done_seen;
            reset_i = 1'b1;
            @(posedge clk); #1;
            reset_i = 1'b0;
            check_reset_outputs("rm_abort");
            // A write whose strobe was sampled before reset has landed.
            if (k == 2) ref_b[12'h041] = wd[7:0];
            last_rdata = 32'h0;
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (done_seen != d0) begin fails++; $display("FAIL rm_no_done: got %0d pulses required 0", done_seen - d0); end
            do_txn(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, "rm_reload");
        end
    endtask

    task automatic test_ignore_busy;
        bit f;
        int elat, erds, ewrs, d0;
        d0 = done_seen;
        model_req(1'b1, 2'b01, 1'b0, 12'h082, 32'h0000BEEF, f, elat, erds, ewrs);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b01; unsigned_i = 1'b0; addr_i = 12'h082; wdata_i = 32'h0000BEEF;
        @(negedge clk);
        we_i = 1'b0; size_i = 2'b10; addr_i = 12'h080;
        repeat (2) @(negedge clk);
        @(negedge clk);
        req_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_seen - d0 != 1) begin fails++; $display("FAIL ignore_busy_done: got %0d pulses required 1", done_seen - d0); end
        checks++;
        if (rdata_o !== last_rdata) begin fails++; $display("FAIL ignore_busy_rdata: got %h required %h", rdata_o, last_rdata); end
        checks++;
        if (bram[32] !== ref_word(32)) begin fails++; $display("FAIL ignore_busy_mem: got %h required %h", bram[32], ref_word(32)); end
    endtask

    task automatic test_mem_compare;
        for (int w = 0; w < 1024; w++) begin
            checks++;
            if (bram[w] !== ref_word(w)) begin
                fails++;
                $display("FAIL mem_word[%0d]: got %h required %h", w, bram[w], ref_word(w));
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) preload(w, $urandom);
        test_reset;
        test_directed;
        test_random;
        test_reset_mid;
        test_ignore_busy;
        test_mem_compare;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
